// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pio_pkg
//  Description : Shared constants and types for the PIO instruction store:
//                address/word widths, memory depth, the JMP opcode and the
//                program-loader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pio_pkg;

    localparam int PIO_ADDR_W    = 5;
    localparam int PIO_INSTR_W   = 16;
    localparam int PIO_MEM_DEPTH = 32;

    // Major opcode field [15:13] of a JMP instruction.
    localparam logic [2:0] OP_JMP = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } pio_state_e;

endpackage
`default_nettype wire

// File: rtl/pio_instr_mem.sv
`default_nettype none
// ============================================================================
//  Module      : pio_instr_mem
//  Description : Instruction memory, 2**ADDR_W x DATA_W register array.
//                One synchronous write port, NUM_SM asynchronous read ports,
//                synchronous clear of every word on reset.
//  Ports       : clk, reset_n          - clock, sync active-low reset
//                wr_en/wr_addr/wr_data - write port (written on posedge)
//                rd_addr (packed)      - NUM_SM read addresses
//                rd_data (packed)      - NUM_SM read words, combinational
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_instr_mem
    import pio_pkg::*;
#(
    parameter int NUM_SM = 4,
    parameter int ADDR_W = PIO_ADDR_W,
    parameter int DATA_W = PIO_INSTR_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_SM*ADDR_W-1:0]   rd_addr,
    output logic [NUM_SM*DATA_W-1:0]   rd_data
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];

    // Reset clears every word to 0, which decodes as "JMP 0".
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Reads see the pre-write contents during a write cycle.
    generate
        for (genvar k = 0; k < NUM_SM; k++) begin : g_rd_port
            assign rd_data[k*DATA_W +: DATA_W] = r_mem[rd_addr[k*ADDR_W +: ADDR_W]];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pio_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : pio_prog_loader
//  Description : Write side of the PIO instruction store. Streams DATA_W-bit
//                instruction words into the instruction memory starting at a
//                load origin (wrapping modulo the depth), optionally relocating
//                JMP targets by the origin, and stalls the state machines while
//                a load is in progress.
//  Ports       : clk, reset_n              - clock, sync active-low reset
//                load_start/origin/len/relocate - load command (IDLE only)
//                load_abort                - terminates a load in progress
//                in_valid/in_ready/in_data - instruction word stream
//                busy, sm_hold             - high while loading
//                done                      - one-cycle completion pulse
//                error                     - one-cycle bad-length pulse
//                used_mask                 - slots written since reset
//                rd_addr/rd_data           - per-SM combinational read ports
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_prog_loader
    import pio_pkg::*;
#(
    parameter int NUM_SM = 4,
    parameter int ADDR_W = PIO_ADDR_W,
    parameter int DATA_W = PIO_INSTR_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load_start,
    input  logic [ADDR_W-1:0]          load_origin,
    input  logic [ADDR_W:0]            load_len,
    input  logic                       relocate,
    input  logic                       load_abort,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       busy,
    output logic                       sm_hold,
    output logic                       done,
    output logic                       error,
    output logic [(2**ADDR_W)-1:0]     used_mask,
    input  logic [NUM_SM*ADDR_W-1:0]   rd_addr,
    output logic [NUM_SM*DATA_W-1:0]   rd_data
);

    localparam int c_depth = 2 ** ADDR_W;

    pio_state_e              r_state;
    pio_state_e              w_next_state;
    logic [ADDR_W-1:0]       r_origin;
    logic [ADDR_W:0]         r_len;
    logic [ADDR_W-1:0]       r_cnt;
    logic                    r_relocate;
    logic                    r_error;
    logic [c_depth-1:0]      r_used;

    logic                    w_len_ok;
    logic                    w_accept;
    logic                    w_xfer;
    logic                    w_last;
    logic [ADDR_W:0]         w_cnt_inc;
    logic [ADDR_W-1:0]       w_wr_addr;
    logic [ADDR_W-1:0]       w_reloc_tgt;
    logic [DATA_W-1:0]       w_wr_data;

    assign w_len_ok  = (load_len != '0) && (load_len <= (ADDR_W+1)'(c_depth));
    assign w_accept  = (r_state == IDLE) && load_start && w_len_ok;
    assign w_xfer    = (r_state == LOAD) && in_valid;
    assign w_cnt_inc = {1'b0, r_cnt} + {{ADDR_W{1'b0}}, 1'b1};
    assign w_last    = (w_cnt_inc == r_len);

    // Both operands are ADDR_W wide, so the sum wraps modulo the depth.
    assign w_wr_addr   = r_origin + r_cnt;
    assign w_reloc_tgt = in_data[ADDR_W-1:0] + r_origin;
    assign w_wr_data   = (r_relocate && (in_data[DATA_W-1 -: 3] == OP_JMP))
                         ? {in_data[DATA_W-1:ADDR_W], w_reloc_tgt}
                         : in_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Abort wins over completion: an aborted load never reports done.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (load_abort) begin
                    w_next_state = IDLE;
                end else if (w_xfer && w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_origin   <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_relocate <= 1'b0;
            r_error    <= 1'b0;
            r_used     <= '0;
        end else begin
            r_error <= (r_state == IDLE) && load_start && !w_len_ok;
            if (w_accept) begin
                r_origin   <= load_origin;
                r_len      <= load_len;
                r_relocate <= relocate;
                r_cnt      <= '0;
            end else if (w_xfer) begin
                r_cnt <= r_cnt + ADDR_W'(1);
            end
            if (w_xfer) begin
                r_used[w_wr_addr] <= 1'b1;
            end
        end
    end

    assign sm_hold   = busy;
    assign error     = r_error;
    assign used_mask = r_used;

    pio_instr_mem #(
        .NUM_SM (NUM_SM),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (w_xfer),
        .wr_addr (w_wr_addr),
        .wr_data (w_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_pio_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pio_prog_loader
//  Description : Self-checking bench for pio_prog_loader. A table of load
//                commands is applied in a loop; every transferred word pushes
//                its expected slot/content onto a scoreboard queue, which is
//                popped and compared through the read ports once the load ends.
//                Hand-written sequences cover the read/write collision and a
//                reset in the middle of a load.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_prog_loader;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load_start;
    logic [4:0]   load_origin;
    logic [5:0]   load_len;
    logic         relocate;
    logic         load_abort;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic         busy;
    logic         sm_hold;
    logic         done;
    logic         error;
    logic [31:0]  used_mask;
    logic [19:0]  rd_addr;
    logic [63:0]  rd_data;

    always #5 clk = ~clk;

    pio_prog_loader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_start  (load_start),
        .load_origin (load_origin),
        .load_len    (load_len),
        .relocate    (relocate),
        .load_abort  (load_abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .busy        (busy),
        .sm_hold     (sm_hold),
        .done        (done),
        .error       (error),
        .used_mask   (used_mask),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    typedef struct packed {
        logic [4:0]        origin;
        logic [5:0]        len;
        logic              reloc;
        logic              toggle;     // in_valid only on odd cycles
        logic [3:0]        abort_at;   // transfer index carrying the abort, F = none
        logic [7:0][15:0]  words;
    } vec_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] data;
    } sb_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    sb_t         sb_q[$];
    logic [15:0] m_mem [32];
    logic [31:0] m_used;
    vec_t        vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [4:0] origin, input logic [5:0] len,
                                input logic reloc, input logic toggle, input logic [3:0] abort_at,
                                input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [15:0] w3,
                                input logic [15:0] w4);
        vec_t v;
        v          = '0;
        v.origin   = origin;
        v.len      = len;
        v.reloc    = reloc;
        v.toggle   = toggle;
        v.abort_at = abort_at;
        v.words[0] = w0;
        v.words[1] = w1;
        v.words[2] = w2;
        v.words[3] = w3;
        v.words[4] = w4;
        return v;
    endfunction

    // Reference behaviour: JMP (opcode 000) targets move by the origin, modulo 32.
    function automatic logic [15:0] exp_word(input logic [15:0] w, input logic [4:0] org,
                                             input logic rel);
        logic [4:0] t;
        t = w[4:0] + org;
        if (rel && (w[15:13] == 3'b000)) return {w[15:5], t};
        return w;
    endfunction

    // Reads one slot through a given port, sampled on the falling edge.
    task automatic read_port(input int port, input logic [4:0] a, output logic [15:0] d);
        rd_addr[port*5 +: 5] = a;
        @(negedge clk);
        d = rd_data[port*16 +: 16];
    endtask

    task automatic model_reset;
        for (int i = 0; i < 32; i++) m_mem[i] = 16'h0000;
        m_used = 32'h0;
        sb_q.delete();
    endtask

    task automatic verify_sb;
        sb_t         e;
        logic [15:0] d;
        int          p;
        p = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            read_port(p, e.addr, d);
            check($sformatf("mem[%0d] port%0d", e.addr, p), {16'h0, d}, {16'h0, e.data});
            p = (p + 1) % 4;
        end
        tick;
        check("used_mask", used_mask, m_used);
    endtask

    task automatic check_all_mem;
        logic [15:0] d;
        for (int a = 0; a < 32; a++) begin
            read_port(a % 4, 5'(a), d);
            check($sformatf("full mem[%0d]", a), {16'h0, d}, {16'h0, m_mem[a]});
        end
        tick;
    endtask

    task automatic run_load(input vec_t v);
        int   xfers;
        int   cyc;
        int   busy_cycles;
        logic aborted;
        logic [4:0] a;
        load_origin = v.origin;
        load_len    = v.len;
        relocate    = v.reloc;
        load_start  = 1'b1;
        tick;
        load_start  = 1'b0;
        if (v.len == 6'd0 || v.len > 6'd32) begin
            check("error pulse", {31'h0, error}, 32'h1);
            check("busy on bad len", {31'h0, busy}, 32'h0);
            tick;
            check("error clears", {31'h0, error}, 32'h0);
            check("busy stays low", {31'h0, busy}, 32'h0);
            return;
        end
        check("busy after start", {31'h0, busy}, 32'h1);
        check("sm_hold after start", {31'h0, sm_hold}, 32'h1);
        check("in_ready after start", {31'h0, in_ready}, 32'h1);
        xfers = 0;
        cyc = 0;
        busy_cycles = 0;
        aborted = 1'b0;
        while (xfers < int'(v.len) && cyc < 100 && !aborted) begin
            in_valid   = v.toggle ? ((cyc % 2) == 1) : 1'b1;
            in_data    = v.words[xfers];
            load_abort = in_valid && (xfers == int'(v.abort_at));
            if (busy) busy_cycles++;
            if (in_valid && in_ready) begin
                a = v.origin + 5'(xfers);
                sb_q.push_back('{addr: a, data: exp_word(in_data, v.origin, v.reloc)});
                m_mem[a]  = exp_word(in_data, v.origin, v.reloc);
                m_used[a] = 1'b1;
                xfers++;
                aborted = load_abort;
            end
            tick;
            cyc++;
            in_valid   = 1'b0;
            load_abort = 1'b0;
        end
        if (cyc >= 100) check("load timeout", 32'h0, 32'h1);
        if (aborted) begin
            check("busy after abort", {31'h0, busy}, 32'h0);
            check("no done on abort", {31'h0, done}, 32'h0);
            tick;
            check("no late done", {31'h0, done}, 32'h0);
        end else begin
            check("done pulse", {31'h0, done}, 32'h1);
            check("busy in done", {31'h0, busy}, 32'h0);
            check("in_ready in done", {31'h0, in_ready}, 32'h0);
            if (!v.toggle) check("busy cycles", busy_cycles, 32'(v.len));
            tick;
            check("done one cycle", {31'h0, done}, 32'h0);
        end
    endtask

    initial begin
        logic [15:0] d;
        reset_n     = 1'b0;
        load_start  = 1'b0;
        load_origin = '0;
        load_len    = '0;
        relocate    = 1'b0;
        load_abort  = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        rd_addr     = '0;

        vecs[0] = mk(5'd0,  6'd3,  1'b0, 1'b0, 4'hF, 16'hE081, 16'hA042, 16'h0001, 16'h0, 16'h0);
        vecs[1] = mk(5'd30, 6'd3,  1'b1, 1'b0, 4'hF, 16'h0001, 16'hE020, 16'h001F, 16'h0, 16'h0);
        vecs[2] = mk(5'd3,  6'd0,  1'b0, 1'b0, 4'hF, 16'h1111, 16'h0,    16'h0,    16'h0, 16'h0);
        vecs[3] = mk(5'd3,  6'd33, 1'b0, 1'b0, 4'hF, 16'h2222, 16'h0,    16'h0,    16'h0, 16'h0);
        vecs[4] = mk(5'd4,  6'd5,  1'b0, 1'b1, 4'd2, 16'h6001, 16'h6002, 16'h6003, 16'h6004, 16'h6005);
        vecs[5] = mk(5'd12, 6'd4,  1'b1, 1'b1, 4'hF, 16'h0005, 16'h2003, 16'h001C, 16'h8000, 16'h0);
        vecs[6] = mk(5'd31, 6'd1,  1'b0, 1'b0, 4'hF, 16'h1234, 16'h0,    16'h0,    16'h0, 16'h0);

        tick;
        tick;
        reset_n = 1'b1;
        model_reset();
        check("reset in_ready", {31'h0, in_ready}, 32'h0);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset sm_hold", {31'h0, sm_hold}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset error", {31'h0, error}, 32'h0);
        check("reset used_mask", used_mask, 32'h0);

        for (int i = 0; i < 7; i++) begin
            run_load(vecs[i]);
            if (vecs[i].len == 6'd0 || vecs[i].len > 6'd32) check_all_mem();
            verify_sb();
            if (i == 0) check("basic used_mask", used_mask, 32'h0000_0007);
            if (i == 1) begin
                read_port(0, 5'd30, d); check("wrap mem[30]", {16'h0, d}, 32'h0000_001F);
                read_port(1, 5'd31, d); check("wrap mem[31]", {16'h0, d}, 32'h0000_E020);
                read_port(2, 5'd0,  d); check("wrap mem[0]",  {16'h0, d}, 32'h0000_001D);
                tick;
            end
            if (i == 4) check("abort used 4..6", used_mask & 32'h0000_00F0, 32'h0000_0070);
        end

        // Read of the slot being written returns old data until the next cycle.
        rd_addr     = '0;
        rd_addr[4:0] = 5'd7;
        load_origin = 5'd7;
        load_len    = 6'd1;
        relocate    = 1'b0;
        load_start  = 1'b1;
        tick;
        load_start  = 1'b0;
        in_valid    = 1'b1;
        in_data     = 16'hA0A0;
        #1;
        check("collision old data", {16'h0, rd_data[15:0]}, 32'h0000_0000);
        tick;
        in_valid    = 1'b0;
        check("collision new data", {16'h0, rd_data[15:0]}, 32'h0000_A0A0);
        check("collision done", {31'h0, done}, 32'h1);
        tick;

        // Reset after two of four words: everything returns to the reset state.
        load_origin = 5'd8;
        load_len    = 6'd4;
        load_start  = 1'b1;
        tick;
        load_start  = 1'b0;
        in_valid    = 1'b1;
        in_data     = 16'h4141;
        tick;
        in_data     = 16'h4242;
        tick;
        in_valid    = 1'b0;
        check("busy mid-load", {31'h0, busy}, 32'h1);
        reset_n     = 1'b0;
        tick;
        reset_n     = 1'b1;
        model_reset();
        check("busy after reset", {31'h0, busy}, 32'h0);
        check("done after reset", {31'h0, done}, 32'h0);
        check("used after reset", used_mask, 32'h0);
        tick;
        check("no done after reset", {31'h0, done}, 32'h0);
        check_all_mem();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pio_prog_loader.md
Name: pio_prog_loader

Overview:
- Write side of the PIO instruction store: accepts a stream of 16-bit instruction words and writes them into the 32-entry instruction memory.
- Provides combinational read ports, one per state machine, which the program counters index every cycle.
- Optionally relocates JMP targets by the load origin, so position-independent programs run at any offset.
- Holds the state machines stalled while a load is in progress.

Parameters:
- NUM_SM, 4, number of state-machine read ports.
- ADDR_W, 5, instruction address width (memory depth 2**ADDR_W = 32).
- DATA_W, 16, instruction word width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- load_start  in  1  single-cycle pulse; begins a load. Sampled only in IDLE.
- load_origin  in  ADDR_W  first write address, latched on load_start.
- load_len  in  ADDR_W+1  word count, valid range 1..32, latched on load_start.
- relocate  in  1  enables JMP target relocation, latched on load_start.
- load_abort  in  1  terminates the load in progress.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  DATA_W  instruction word.
- busy  out  1  high in LOAD.
- sm_hold  out  1  stall request to all state machines; equals busy.
- done  out  1  one-cycle pulse on load completion.
- error  out  1  one-cycle pulse on a rejected load_start.
- used_mask  out  32  bit i set when slot i has been written since reset.
- rd_addr  in  NUM_SM*ADDR_W  per-SM read address (SM k in bits [k*5 +: 5]).
- rd_data  out  NUM_SM*DATA_W  per-SM instruction (SM k in bits [k*16 +: 16]).

Behaviour:
- Reset (reset_n low at posedge):
  - FSM goes to IDLE and the internal counter clears.
  - in_ready, busy, sm_hold, done and error are 0; used_mask is 0.
  - All memory words clear to 16'h0000 (JMP 0).
  - Reset takes priority over every other input; a reset during LOAD discards the load with no done pulse.
- IDLE, on load_start:
  - If load_len==0 or load_len>32: pulse error for the next cycle and stay in IDLE.
  - Otherwise latch origin, len and relocate, clear cnt, and enter LOAD on the next cycle.
- LOAD:
  - in_ready=1 and busy=1.
  - A word transfers on any cycle with in_valid && in_ready.
  - Write address = (origin + cnt) mod 32, using 5-bit wrap-around arithmetic. origin=30 with len=4 writes slots 30, 31, 0, 1.
  - The word is written on the same posedge it transfers, and used_mask[addr] is set.
  - cnt increments by one per transfer.
  - The transfer with cnt==len-1 moves the FSM to DONE.
- DONE:
  - Lasts exactly one cycle; done=1, in_ready=0, busy=0.
  - Returns to IDLE.
  - Latency: the done pulse appears in the cycle after the last write.
- Relocation:
  - Applies when relocate=1 and in_data[15:13]==3'b000 (JMP).
  - Stored word = {in_data[15:5], (in_data[4:0]+origin) mod 32}.
  - All other opcodes, and all words when relocate=0, are stored unmodified.
- Abort:
  - load_abort in LOAD returns the FSM to IDLE on the next edge, with no done pulse.
  - Words already written stay in memory and in used_mask.
  - If load_abort coincides with a transfer, the word is written before the abort.
  - load_abort outside LOAD is ignored.
- load_start in LOAD or DONE is ignored.
- Reads:
  - rd_data is combinational from memory: rd_data[k] = mem[rd_addr[k]].
  - A read of the slot being written in the same cycle returns the old contents; the new value is visible from the next cycle.
  - Any number of ports may read the same address.
- sm_hold=busy. The program counters treat it as stalled, so a program cannot run while it is being overwritten.

Decomposition:
- Shared package pio_pkg holds:
  - PIO_ADDR_W=5, PIO_INSTR_W=16, PIO_MEM_DEPTH=32;
  - opcode constant OP_JMP=3'b000;
  - the FSM state enum {IDLE, LOAD, DONE}.
- One sub-module, pio_instr_mem: 32x16 register array with one synchronous write port, NUM_SM asynchronous read ports, and synchronous clear on reset.
- Relocation and the FSM stay in pio_prog_loader.

Test Plan:
- Basic load: origin=0, len=3, relocate=0, words 16'hE081, 16'hA042, 16'h0001 streamed with in_valid held high. Required: mem[0..2] match the inputs, done pulses 1 cycle after the 3rd transfer, used_mask=32'h7, busy high for exactly 3 cycles.
- Wrap and relocate: origin=30, len=3, relocate=1, words 16'h0001, 16'hE020, 16'h001F. Required: mem[30]=16'h001F, mem[31]=16'hE020, mem[0]=16'h001D.
- Bad length: load_start with len=0, then with len=33. Required: error pulses once for each, busy stays 0, memory unchanged.
- Backpressure and abort: origin=4, len=5, with in_valid toggling every other cycle; load_abort asserted coincident with the 3rd transfer. Required: slots 4..6 written, no done pulse, FSM in IDLE, used_mask bits 4..6 set.
- Read/write collision: rd_addr[0]=7 while slot 7 is written from 16'h0000 to 16'hA0A0. Required: rd_data[0]=16'h0000 in the write cycle and 16'hA0A0 in the next cycle.
- Reset mid-load: reset_n low for one cycle after 2 of 4 words. Required: busy=0, done never pulses, all memory and used_mask are 0.
